// File: rtl/abr_prim_sum_gather.sv
// abr_prim_sum_gather: packs a serial valid/ready beat stream into an NumSrc-lane vector for a sum tree
module abr_prim_sum_gather #(
  parameter int NumSrc = 32,
  parameter int Width  = 8,
  localparam int CntW  = $clog2(NumSrc + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_b,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [Width-1:0]               in_value_i,
  input  logic                           in_skip_i,
  input  logic                           in_last_i,
  output logic                           vec_valid_o,
  input  logic                           vec_ready_i,
  output logic [NumSrc-1:0][Width-1:0]   values_o,
  output logic [NumSrc-1:0]              valid_o,
  output logic [CntW-1:0]                count_o
);
  localparam int IdxW = $clog2(NumSrc);
  if (NumSrc < 2) begin : g_chk
    $error("abr_prim_sum_gather: NumSrc must be >= 2");
  end
  typedef enum logic {FILL, HOLD} state_e;
  state_e                       state_q, state_d;
  logic [CntW-1:0]              idx_q, idx_d;
  logic [NumSrc-1:0][Width-1:0] values_q, values_d;
  logic [NumSrc-1:0]            valid_q, valid_d;
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    values_d = values_q;
    valid_d  = valid_q;
    if (state_q == FILL && in_valid_i) begin
      values_d[idx_q[IdxW-1:0]] = in_skip_i ? '0 : in_value_i;
      valid_d[idx_q[IdxW-1:0]]  = ~in_skip_i;
      idx_d   = idx_q + CntW'(1);
      // a full vector closes even without in_last_i
      state_d = (in_last_i || idx_q == CntW'(NumSrc - 1)) ? HOLD : FILL;
    end else if (state_q == HOLD && vec_ready_i) begin
      state_d  = FILL;
      idx_d    = '0;
      values_d = '0;
      valid_d  = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_b) begin
      state_q  <= FILL;
      idx_q    <= '0;
      values_q <= '0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      values_q <= values_d;
      valid_q  <= valid_d;
    end
  end
  assign in_ready_o  = rst_b & (state_q == FILL);
  assign vec_valid_o = rst_b & (state_q == HOLD);
  assign values_o    = values_q;
  assign valid_o     = valid_q;
  assign count_o     = idx_q;
endmodule

// File: tb/tb_abr_prim_sum_gather.sv
// tb_abr_prim_sum_gather: directed checks of packing, skip, early last, backpressure and reset
module tb_abr_prim_sum_gather;
  logic             clk_i = 1'b0;
  logic             rst_b;
  logic             in_valid_i, in_skip_i, in_last_i, vec_ready_i;
  logic [7:0]       in_value_i;
  logic             in_ready_o, vec_valid_o;
  logic [31:0][7:0] values_o;
  logic [31:0]      valid_o;
  logic [5:0]       count_o;
  int               tests = 0;
  int               fails = 0;
  int               hs_cnt = 0;
  logic [31:0][7:0] exp_v;
  abr_prim_sum_gather #(.NumSrc(32), .Width(8)) dut (
    .clk_i(clk_i), .rst_b(rst_b), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_value_i(in_value_i), .in_skip_i(in_skip_i), .in_last_i(in_last_i),
    .vec_valid_o(vec_valid_o), .vec_ready_i(vec_ready_i), .values_o(values_o),
    .valid_o(valid_o), .count_o(count_o)
  );
  always #5 clk_i = ~clk_i;
  always @(negedge clk_i) if (vec_valid_o) hs_cnt++;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] lane_sum(input logic [31:0][7:0] v, input logic [31:0] m);
    logic [7:0] s = '0;
    for (int k = 0; k < 32; k++) s += m[k] ? v[k] : 8'h00;
    return s;
  endfunction
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic send(input logic [7:0] v, input logic skip, input logic last);
    logic got = 1'b0;
    in_valid_i = 1'b1;
    in_value_i = v;
    in_skip_i  = skip;
    in_last_i  = last;
    for (int i = 0; i < 20 && !got; i++) begin
      got = in_ready_o;
      tick();
    end
    in_valid_i = 1'b0;
    in_skip_i  = 1'b0;
    in_last_i  = 1'b0;
    chk("beat_accepted", {255'd0, got}, 256'd1);
  endtask
  task automatic release_vec();
    vec_ready_i = 1'b1;
    tick();
    vec_ready_i = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst_b = 1'b0; in_valid_i = 1'b0; in_skip_i = 1'b0; in_last_i = 1'b0;
    vec_ready_i = 1'b0; in_value_i = '0;
    tick();
    tick();
    chk("rst_in_ready_gated", {255'd0, in_ready_o}, 256'd0);
    rst_b = 1'b1;
    #1;
    chk("rst_in_ready", {255'd0, in_ready_o}, 256'd1);
    chk("rst_vec_valid", {255'd0, vec_valid_o}, 256'd0);
    chk("rst_count", {250'd0, count_o}, 256'd0);
    chk("rst_valid", {224'd0, valid_o}, 256'd0);
    chk("rst_values", values_o, 256'd0);
    // full vector 1..32 without in_last_i
    for (int k = 0; k < 31; k++) send(8'(k + 1), 1'b0, 1'b0);
    chk("full_not_yet", {255'd0, vec_valid_o}, 256'd0);
    send(8'd32, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) exp_v[k] = 8'(k + 1);
    chk("full_vec_valid", {255'd0, vec_valid_o}, 256'd1);
    chk("full_in_ready", {255'd0, in_ready_o}, 256'd0);
    chk("full_valid", {224'd0, valid_o}, {224'd0, 32'hFFFF_FFFF});
    chk("full_values", values_o, exp_v);
    chk("full_count", {250'd0, count_o}, 256'd32);
    chk("full_sum", {248'd0, lane_sum(values_o, valid_o)}, 256'h10);
    release_vec();
    chk("post_full_ready", {255'd0, in_ready_o}, 256'd1);
    chk("post_full_vvalid", {255'd0, vec_valid_o}, 256'd0);
    chk("post_full_valid", {224'd0, valid_o}, 256'd0);
    chk("post_full_count", {250'd0, count_o}, 256'd0);
    // early last
    send(8'd5, 1'b0, 1'b0);
    send(8'd6, 1'b0, 1'b0);
    send(8'd7, 1'b0, 1'b1);
    chk("early_vec_valid", {255'd0, vec_valid_o}, 256'd1);
    chk("early_valid", {224'd0, valid_o}, 256'h7);
    chk("early_values", values_o, 256'h070605);
    chk("early_count", {250'd0, count_o}, 256'd3);
    release_vec();
    // skip lane, then backpressure while holding
    send(8'd9, 1'b0, 1'b0);
    send(8'hAA, 1'b1, 1'b0);
    send(8'd4, 1'b0, 1'b1);
    chk("skip_valid", {224'd0, valid_o}, 256'h5);
    chk("skip_values", values_o, 256'h040009);
    chk("skip_count", {250'd0, count_o}, 256'd3);
    chk("skip_sum", {248'd0, lane_sum(values_o, valid_o)}, 256'd13);
    in_valid_i = 1'b1;
    in_value_i = 8'h33;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_in_ready", {255'd0, in_ready_o}, 256'd0);
      chk("bp_vec_valid", {255'd0, vec_valid_o}, 256'd1);
      chk("bp_values", values_o, 256'h040009);
      chk("bp_valid_count", {218'd0, valid_o, count_o}, {218'd0, 32'h5, 6'd3});
    end
    vec_ready_i = 1'b1;
    tick();
    vec_ready_i = 1'b0;
    chk("bp_ready_back", {255'd0, in_ready_o}, 256'd1);
    chk("bp_cleared", {218'd0, valid_o, count_o}, 256'd0);
    tick();
    in_valid_i = 1'b0;
    chk("bp_lane0_value", values_o, 256'h33);
    chk("bp_lane0_valid", {218'd0, valid_o, count_o}, {218'd0, 32'h1, 6'd1});
    send(8'h44, 1'b1, 1'b1);
    chk("skip_last_valid", {224'd0, valid_o}, 256'h1);
    chk("skip_last_hold", {254'd0, vec_valid_o, in_ready_o}, 256'b10);
    release_vec();
    // reset mid-fill
    for (int k = 0; k < 5; k++) send(8'(k + 1), 1'b0, 1'b0);
    chk("mid_count", {250'd0, count_o}, 256'd5);
    rst_b = 1'b0;
    tick();
    chk("mid_rst_gate", {254'd0, in_ready_o, vec_valid_o}, 256'd0);
    rst_b = 1'b1;
    #1;
    chk("mid_rst_count", {250'd0, count_o}, 256'd0);
    chk("mid_rst_valid", {224'd0, valid_o}, 256'd0);
    chk("mid_rst_values", values_o, 256'd0);
    chk("mid_rst_fill", {254'd0, in_ready_o, vec_valid_o}, 256'b10);
    // back-to-back with vec_ready_i tied high
    vec_ready_i = 1'b1;
    hs_cnt = 0;
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b1);
    chk("b2b_v1_values", values_o, 256'h2211);
    chk("b2b_v1_valid", {218'd0, valid_o, count_o}, {218'd0, 32'h3, 6'd2});
    send(8'h0A, 1'b0, 1'b0);
    send(8'h0B, 1'b0, 1'b0);
    send(8'h0C, 1'b0, 1'b1);
    chk("b2b_v2_values", values_o, 256'h0C0B0A);
    chk("b2b_v2_valid", {218'd0, valid_o, count_o}, {218'd0, 32'h7, 6'd3});
    tick();
    vec_ready_i = 1'b0;
    chk("b2b_fill", {254'd0, in_ready_o, vec_valid_o}, 256'b10);
    chk("b2b_hs_count", 256'(hs_cnt), 256'd2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
